// File: rtl/product_accumulator.sv
// MAC back-end: sums a burst of unsigned 32-bit products into a wide accumulator
// and hands the total downstream over a valid/ready handshake.
module product_accumulator #(
   parameter int   ACC_W     = 40,
   parameter int   MAX_TERMS = 16,
   localparam int  CNT_W     = $clog2(MAX_TERMS + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      product,
   input  logic             in_last,
   input  logic             acc_clr,
   output logic             acc_valid,
   input  logic             acc_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic [CNT_W-1:0] term_count,
   output logic             acc_ovf
);

   typedef enum logic {ACC, DONE} state_t;

   state_t           state, state_nxt;
   logic [ACC_W-1:0] acc_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             ovf_nxt;
   logic [ACC_W:0]   sum;
   logic             accept;
   logic             close;

   assign in_ready  = (state == ACC) && !acc_clr;
   assign acc_valid = (state == DONE);
   assign accept    = in_valid && in_ready;

   // Extra top bit of the sum captures the carry out of the accumulator.
   assign sum   = {1'b0, acc_out} + (ACC_W + 1)'(product);
   assign close = in_last || (term_count == CNT_W'(MAX_TERMS - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ACC;
         acc_out    <= '0;
         term_count <= '0;
         acc_ovf    <= 1'b0;
      end else begin
         state      <= state_nxt;
         acc_out    <= acc_nxt;
         term_count <= cnt_nxt;
         acc_ovf    <= ovf_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc_out;
      cnt_nxt   = term_count;
      ovf_nxt   = acc_ovf;
      case (state)
         ACC: begin
            if (acc_clr) begin
               acc_nxt = '0;
               cnt_nxt = '0;
               ovf_nxt = 1'b0;
            end else if (accept) begin
               acc_nxt = sum[ACC_W-1:0];
               cnt_nxt = term_count + CNT_W'(1);
               ovf_nxt = acc_ovf | sum[ACC_W];
               if (close) state_nxt = DONE;
            end
         end
         DONE: begin
            if (acc_ready) begin
               state_nxt = ACC;
               acc_nxt   = '0;
               cnt_nxt   = '0;
               ovf_nxt   = 1'b0;
            end
         end
         default: state_nxt = ACC;
      endcase
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed self-checking bench for product_accumulator (ACC_W=40 and ACC_W=33 instances).
module tb_product_accumulator;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] product;
   logic        in_last;
   logic        acc_clr;
   logic        acc_ready;

   logic        in_ready;
   logic        acc_valid;
   logic [39:0] acc_out;
   logic [4:0]  term_count;
   logic        acc_ovf;

   logic        in_ready33;
   logic        acc_valid33;
   logic [32:0] acc_out33;
   logic [4:0]  term_count33;
   logic        acc_ovf33;

   int checks   = 0;
   int failures = 0;

   product_accumulator #(.ACC_W(40), .MAX_TERMS(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .product(product), .in_last(in_last), .acc_clr(acc_clr),
      .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_out(acc_out),
      .term_count(term_count), .acc_ovf(acc_ovf)
   );

   product_accumulator #(.ACC_W(33), .MAX_TERMS(16)) dut33 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready33),
      .product(product), .in_last(in_last), .acc_clr(acc_clr),
      .acc_valid(acc_valid33), .acc_ready(acc_ready), .acc_out(acc_out33),
      .term_count(term_count33), .acc_ovf(acc_ovf33)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] product;
      logic        last;
      logic [39:0] exp_acc;
      logic [4:0]  exp_cnt;
      logic        exp_ovf;
      logic        exp_valid;
   } beat_t;

   beat_t vec[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [31:0] p, input logic l, input logic [39:0] a,
                      input logic [4:0] c, input logic o, input logic v);
      beat_t b;
      b.product = p; b.last = l; b.exp_acc = a; b.exp_cnt = c; b.exp_ovf = o; b.exp_valid = v;
      vec.push_back(b);
   endtask

   task automatic release_result();
      in_valid  = 1'b0;
      acc_ready = 1'b1;
      step();
      acc_ready = 1'b0;
      chk("rel_valid", 64'(acc_valid), 64'd0);
      chk("rel_acc",   64'(acc_out),   64'd0);
      chk("rel_cnt",   64'(term_count), 64'd0);
      chk("rel_ovf",   64'(acc_ovf),   64'd0);
      chk("rel_ready", 64'(in_ready),  64'd1);
   endtask

   initial begin
      logic [39:0] hold_acc;
      logic [4:0]  hold_cnt;
      bit          held;

      // Reset with in_valid asserted
      rst_n = 1'b0; in_valid = 1'b1; product = 32'd5; in_last = 1'b0;
      acc_clr = 1'b0; acc_ready = 1'b0;
      step();
      step();
      chk("rst_valid", 64'(acc_valid),  64'd0);
      chk("rst_acc",   64'(acc_out),    64'd0);
      chk("rst_cnt",   64'(term_count), 64'd0);
      chk("rst_ovf",   64'(acc_ovf),    64'd0);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      step();
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_acc_idle", 64'(acc_out),  64'd0);

      // Burst 5, 7, 0xFFFFFFFF (last)
      add(32'd5,          1'b0, 40'd5,             5'd1, 1'b0, 1'b0);
      add(32'd7,          1'b0, 40'd12,            5'd2, 1'b0, 1'b0);
      add(32'hFFFF_FFFF,  1'b1, 40'h01_0000_000B,  5'd3, 1'b0, 1'b1);
      // Single-term burst
      add(32'h0000_1234,  1'b1, 40'h1234,          5'd1, 1'b0, 1'b1);
      // 16 beats of 1 with no last: closes on the 16th
      for (int unsigned k = 1; k <= 16; k++)
         add(32'd1, 1'b0, 40'(k), 5'(k), 1'b0, (k == 16) ? 1'b1 : 1'b0);
      // Values that wrap a 33-bit accumulator
      add(32'hFFFF_FFFF,  1'b0, 40'h00_FFFF_FFFF,  5'd1, 1'b0, 1'b0);
      add(32'hFFFF_FFFF,  1'b0, 40'h01_FFFF_FFFE,  5'd2, 1'b0, 1'b0);
      add(32'h0000_0002,  1'b1, 40'h02_0000_0000,  5'd3, 1'b0, 1'b1);

      held = 1'b0;
      for (int i = 0; i < vec.size(); i++) begin
         in_valid = 1'b1;
         product  = vec[i].product;
         in_last  = vec[i].last;
         #1;
         chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
         step();
         chk($sformatf("v%0d_acc", i),   64'(acc_out),    64'(vec[i].exp_acc));
         chk($sformatf("v%0d_cnt", i),   64'(term_count), 64'(vec[i].exp_cnt));
         chk($sformatf("v%0d_ovf", i),   64'(acc_ovf),    64'(vec[i].exp_ovf));
         chk($sformatf("v%0d_valid", i), 64'(acc_valid),  64'(vec[i].exp_valid));
         if (vec[i].exp_valid) begin
            chk($sformatf("v%0d_done_ready", i), 64'(in_ready), 64'd0);
            if (vec[i].exp_cnt == 5'd3 && vec[i].exp_acc == 40'h02_0000_0000) begin
               chk("w33_acc",   64'(acc_out33),    64'd0);
               chk("w33_ovf",   64'(acc_ovf33),    64'd1);
               chk("w33_cnt",   64'(term_count33), 64'd3);
               chk("w33_valid", 64'(acc_valid33),  64'd1);
            end
            if (!held) begin
               // Downstream stalls while upstream keeps offering a beat
               held     = 1'b1;
               hold_acc = acc_out;
               hold_cnt = term_count;
               in_valid = 1'b1;
               product  = 32'h55;
               in_last  = 1'b0;
               for (int h = 0; h < 5; h++) begin
                  step();
                  chk("hold_acc",   64'(acc_out),    64'(hold_acc));
                  chk("hold_cnt",   64'(term_count), 64'(hold_cnt));
                  chk("hold_ovf",   64'(acc_ovf),    64'd0);
                  chk("hold_valid", 64'(acc_valid),  64'd1);
                  chk("hold_ready", 64'(in_ready),   64'd0);
               end
            end
            release_result();
         end
      end

      // acc_clr mid-burst with a concurrent beat that must not be consumed
      in_valid = 1'b1; product = 32'd3; in_last = 1'b0;
      step();
      product = 32'd4;
      step();
      chk("clr_pre_acc", 64'(acc_out),    64'd7);
      chk("clr_pre_cnt", 64'(term_count), 64'd2);
      acc_clr = 1'b1;
      product = 32'd9;
      #1;
      chk("clr_in_ready", 64'(in_ready), 64'd0);
      step();
      chk("clr_acc",   64'(acc_out),    64'd0);
      chk("clr_cnt",   64'(term_count), 64'd0);
      chk("clr_valid", 64'(acc_valid),  64'd0);
      acc_clr = 1'b0;
      in_last = 1'b1;
      step();
      chk("clr_after_acc",   64'(acc_out),    64'd9);
      chk("clr_after_cnt",   64'(term_count), 64'd1);
      chk("clr_after_valid", 64'(acc_valid),  64'd1);

      // acc_clr is ignored in DONE
      in_valid = 1'b0; in_last = 1'b0;
      acc_clr  = 1'b1;
      step();
      acc_clr = 1'b0;
      chk("done_clr_acc",   64'(acc_out),   64'd9);
      chk("done_clr_valid", 64'(acc_valid), 64'd1);

      // Reset while holding a result
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("done_rst_valid", 64'(acc_valid),  64'd0);
      chk("done_rst_acc",   64'(acc_out),    64'd0);
      chk("done_rst_cnt",   64'(term_count), 64'd0);
      chk("done_rst_ready", 64'(in_ready),   64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
